prach_packet: RTL and testbench

Packet framer directly downstream of `prach_fft` in the PRACH long-format chain, on `clk_dsp`. Consumes the FFT's serial complex bin stream, packs 4 bins per 128-bit beat, and frames one Avalon-ST packet per antenna-carrier channel with SOP, EOP and channel number. A beat FIFO absorbs output backpressure; output is consumed by the xRAN/Ethernet clock-crossing stage.

---
 rtl/prach_pkg.sv | 22 ++
 rtl/prach_packet_fifo.sv | 62 ++++++
 rtl/prach_packet.sv | 159 +++++++++++++++
 tb/tb_prach_packet.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prach_pkg.sv
// Shared types and constants for the PRACH packet framer: beat record,
// framing FSM states and the antenna/carrier geometry.
package prach_pkg;

  localparam int NUM_ANT = 8;
  localparam int NUM_CC  = 3;
  localparam int LANES   = 4;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  chn;
    logic         sop;
    logic         eop;
  } beat_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_DROP = 2'd2
  } state_t;

endpackage

// File: rtl/prach_packet_fifo.sv
// Single-clock show-ahead beat FIFO: block-RAM array plus a registered output
// stage that always presents the head entry when not empty.
module prach_packet_fifo #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 146
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      mem_cnt_reg, mem_cnt_next;
  logic [AW:0]      level;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             pop, wr_ok, load;

  // Occupancy counts the output stage too, so DEPTH beats fill the FIFO.
  assign level = mem_cnt_reg + (AW + 1)'(out_valid_reg);
  assign full  = (level == (AW + 1)'(DEPTH));
  assign empty = ~out_valid_reg;
  assign pop   = rd_en & out_valid_reg;
  assign wr_ok = wr_en & (~full | pop);
  assign load  = (mem_cnt_reg != '0) & (~out_valid_reg | pop);

  assign mem_cnt_next = mem_cnt_reg + (AW + 1)'(wr_ok) - (AW + 1)'(load);
  assign rd_data      = out_data_reg;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      mem_cnt_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      mem_cnt_reg <= mem_cnt_next;
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (load) begin
        rd_ptr_reg    <= rd_ptr_reg + 1'b1;
        out_data_reg  <= mem[rd_ptr_reg];
        out_valid_reg <= 1'b1;
      end else if (pop) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/prach_packet.sv
// PRACH packet framer: packs 4 FFT bins per 128-bit beat and frames one
// Avalon-ST packet per channel. Define PRACH_PACKET_STATS_EN for counters.
module prach_packet
  import prach_pkg::*;
#(
  parameter int NUM_CHN    = NUM_ANT * NUM_CC,
  parameter int NUM_SC     = 864,
  parameter int FIFO_DEPTH = 512
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  din_dr,
  input  logic [15:0]  din_di,
  input  logic         din_dv,
  input  logic         sync_in,
  output logic [127:0] avst_source_data,
  output logic         avst_source_valid,
  output logic [15:0]  avst_source_channel,
  output logic         avst_source_startofpacket,
  output logic         avst_source_endofpacket,
  input  logic         avst_source_ready,
  output logic         stat_overflow,
  output logic         stat_sync_err,
  output logic [31:0]  stat_pkt_cnt,
  output logic [31:0]  stat_drop_cnt
);

  localparam int BW = $clog2(NUM_SC + 1);
  localparam int CW = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;

  state_t        state_reg, state_next;
  logic [BW-1:0] bin_reg, bin_next, cur_bin;
  logic [CW-1:0] chn_reg, chn_next, cur_chn;
  beat_t         beat_reg, beat_next, fifo_rd;
  logic          push_reg, push_next;
  logic          overflow_reg, sync_err_reg;
  logic          restart, take, beat_done, last_bin, last_chn;
  logic          pop, drop, fifo_full, fifo_empty;

  // A synced bin always restarts at channel 0, bin 0, whatever the state.
  assign restart   = din_dv & sync_in;
  assign take      = din_dv & (restart | (state_reg == ST_PACK));
  assign cur_bin   = restart ? '0 : bin_reg;
  assign cur_chn   = restart ? '0 : chn_reg;
  assign last_bin  = (cur_bin == BW'(NUM_SC - 1));
  assign last_chn  = (cur_chn == CW'(NUM_CHN - 1));
  assign beat_done = take & (cur_bin[1:0] == 2'd3);
  assign pop       = ~fifo_empty & avst_source_ready;
  assign drop      = push_reg & fifo_full & ~pop;
  assign push_next = beat_done & ~(drop & ~restart);

  always_comb begin
    state_next = state_reg;
    bin_next   = bin_reg;
    chn_next   = chn_reg;
    if (take) begin
      if (last_bin) begin
        bin_next = '0;
        if (last_chn) begin
          chn_next   = '0;
          state_next = ST_IDLE;
        end else begin
          chn_next   = cur_chn + 1'b1;
          state_next = ST_PACK;
        end
      end else begin
        bin_next   = cur_bin + 1'b1;
        state_next = ST_PACK;
      end
    end
    if (drop && !restart) state_next = ST_DROP;
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES - 1; gi++) begin : g_lane
      logic [31:0] data_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          data_reg <= '0;
        else if (take && cur_bin[1:0] == 2'(gi))
          data_reg <= {din_dr, din_di};
      end
    end
  endgenerate

  // Lane 3 comes straight from the input so the beat closes on its own bin.
  always_comb begin
    beat_next.data = {g_lane[0].data_reg, g_lane[1].data_reg,
                      g_lane[2].data_reg, din_dr, din_di};
    beat_next.chn  = 16'(cur_chn);
    beat_next.sop  = (cur_bin < BW'(LANES));
    beat_next.eop  = last_bin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      bin_reg      <= '0;
      chn_reg      <= '0;
      push_reg     <= 1'b0;
      beat_reg     <= '0;
      overflow_reg <= 1'b0;
      sync_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      bin_reg   <= bin_next;
      chn_reg   <= chn_next;
      push_reg  <= push_next;
      if (beat_done) beat_reg <= beat_next;
      if (drop) overflow_reg <= 1'b1;
      if (restart && state_reg == ST_PACK && (bin_reg != '0 || chn_reg != '0))
        sync_err_reg <= 1'b1;
    end
  end

  prach_packet_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(beat_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push_reg),
    .wr_data (beat_reg),
    .rd_en   (avst_source_ready),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign avst_source_data          = fifo_rd.data;
  assign avst_source_channel       = fifo_rd.chn;
  assign avst_source_startofpacket = fifo_rd.sop;
  assign avst_source_endofpacket   = fifo_rd.eop;
  assign avst_source_valid         = ~fifo_empty;
  assign stat_overflow             = overflow_reg;
  assign stat_sync_err             = sync_err_reg;

`ifdef PRACH_PACKET_STATS_EN
  logic [31:0] pkt_cnt_reg, drop_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (push_reg && !drop && beat_reg.eop) pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
      if (drop) drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end
  end

  assign stat_pkt_cnt  = pkt_cnt_reg;
  assign stat_drop_cnt = drop_cnt_reg;
`else
  assign stat_pkt_cnt  = '0;
  assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_prach_packet.sv
// Directed bench for prach_packet with a small geometry (2 channels x 8 bins,
// 4-deep FIFO): basic framing, gaps, overflow, sync error, reset, no-sync.
module tb_prach_packet;

  localparam int NCHN  = 2;
  localparam int NSC   = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  din_dr = '0;
  logic [15:0]  din_di = '0;
  logic         din_dv = 1'b0;
  logic         sync_in = 1'b0;
  logic         ready = 1'b0;
  logic [127:0] avst_source_data;
  logic         avst_source_valid;
  logic [15:0]  avst_source_channel;
  logic         avst_source_startofpacket;
  logic         avst_source_endofpacket;
  logic         stat_overflow;
  logic         stat_sync_err;
  logic [31:0]  stat_pkt_cnt;
  logic [31:0]  stat_drop_cnt;

  int checks = 0;
  int failures = 0;
  int ncyc = 0;
  int b3_ncyc = 0;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  chn;
    logic         sop;
    logic         eop;
    int           cyc;
  } obs_t;

  typedef struct {
    logic [15:0]  first_bin;
    logic [127:0] data;
    logic [15:0]  chn;
    logic         sop;
    logic         eop;
  } vec_t;

  obs_t obs[$];
  vec_t vecs[4];

  prach_packet #(
    .NUM_CHN    (NCHN),
    .NUM_SC     (NSC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .din_dr                    (din_dr),
    .din_di                    (din_di),
    .din_dv                    (din_dv),
    .sync_in                   (sync_in),
    .avst_source_data          (avst_source_data),
    .avst_source_valid         (avst_source_valid),
    .avst_source_channel       (avst_source_channel),
    .avst_source_startofpacket (avst_source_startofpacket),
    .avst_source_endofpacket   (avst_source_endofpacket),
    .avst_source_ready         (ready),
    .stat_overflow             (stat_overflow),
    .stat_sync_err             (stat_sync_err),
    .stat_pkt_cnt              (stat_pkt_cnt),
    .stat_drop_cnt             (stat_drop_cnt)
  );

  always #5 clk = ~clk;

  // Transfers are observed on the falling edge, mid-cycle.
  always @(negedge clk) begin
    ncyc++;
    if (avst_source_valid && ready)
      obs.push_back('{avst_source_data, avst_source_channel,
                      avst_source_startofpacket, avst_source_endofpacket, ncyc});
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bin(input logic [15:0] v, input logic s, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        din_dv  = 1'b0;
        sync_in = 1'b1;  // meaningless without din_dv
        @(posedge clk);
        #1;
      end
    end
    din_dr  = v;
    din_di  = 16'h0000 - v;
    din_dv  = 1'b1;
    sync_in = s;
    @(posedge clk);
    #1;
    din_dv  = 1'b0;
    sync_in = 1'b0;
  endtask

  task automatic drive_bins(input logic [15:0] base, input int n, input logic sync_first);
    for (int i = 0; i < n; i++)
      drive_bin(base + 16'(i), sync_first && (i == 0), 1'b0);
  endtask

  task automatic drive_table(input bit gaps);
    for (int v = 0; v < 4; v++) begin
      for (int l = 0; l < 4; l++) begin
        drive_bin(vecs[v].first_bin + 16'(l), (v == 0) && (l == 0), gaps);
        if (v == 0 && l == 3) b3_ncyc = ncyc;
      end
    end
  endtask

  task automatic check_table(input string tag, input int off);
    for (int v = 0; v < 4; v++) begin
      if (off + v >= obs.size()) begin
        checks++;
        failures++;
        $display("FAIL %s.beat%0d: got no beat required one", tag, v);
      end else begin
        check($sformatf("%s.beat%0d.data", tag, v), obs[off+v].data, vecs[v].data);
        check($sformatf("%s.beat%0d.chn", tag, v), 128'(obs[off+v].chn), 128'(vecs[v].chn));
        check($sformatf("%s.beat%0d.sop", tag, v), 128'(obs[off+v].sop), 128'(vecs[v].sop));
        check($sformatf("%s.beat%0d.eop", tag, v), 128'(obs[off+v].eop), 128'(vecs[v].eop));
        $display("%s beat %0d ch=%0d sop=%0b eop=%0b data=%h", tag, v,
                 obs[off+v].chn, obs[off+v].sop, obs[off+v].eop, obs[off+v].data);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    vecs[0] = '{16'd0,  128'h00000000_0001FFFF_0002FFFE_0003FFFD, 16'd0, 1'b1, 1'b0};
    vecs[1] = '{16'd4,  128'h0004FFFC_0005FFFB_0006FFFA_0007FFF9, 16'd0, 1'b0, 1'b1};
    vecs[2] = '{16'd8,  128'h0008FFF8_0009FFF7_000AFFF6_000BFFF5, 16'd1, 1'b1, 1'b0};
    vecs[3] = '{16'd12, 128'h000CFFF4_000DFFF3_000EFFF2_000FFFF1, 16'd1, 1'b0, 1'b1};

    // Reset state
    idle(3);
    check("rst.valid", 128'(avst_source_valid), 128'(0));
    check("rst.data", avst_source_data, 128'(0));
    check("rst.chn", 128'(avst_source_channel), 128'(0));
    check("rst.sop_eop", 128'({avst_source_startofpacket, avst_source_endofpacket}), 128'(0));
    check("rst.flags", 128'({stat_overflow, stat_sync_err}), 128'(0));
    check("rst.cnts", 128'({stat_pkt_cnt, stat_drop_cnt}), 128'(0));
    rst_n = 1'b1;
    idle(1);

    // Basic frame, full rate, ready high
    ready = 1'b1;
    obs.delete();
    drive_table(1'b0);
    idle(10);
    check("basic.count", 128'(obs.size()), 128'(4));
    check_table("basic", 0);
    if (obs.size() > 0)
      check("basic.latency", 128'(obs[0].cyc - b3_ncyc), 128'(3));
    check("basic.flags", 128'({stat_overflow, stat_sync_err}), 128'(0));
`ifdef PRACH_PACKET_STATS_EN
    check("basic.pkt_cnt", 128'(stat_pkt_cnt), 128'(2));
`else
    check("basic.pkt_cnt", 128'(stat_pkt_cnt), 128'(0));
`endif

    // Same frame with random input gaps
    obs.delete();
    drive_table(1'b1);
    idle(10);
    check("gaps.count", 128'(obs.size()), 128'(4));
    check_table("gaps", 0);

    // Overflow: 4-deep FIFO filled with ready low, second frame drops
    do_reset();
    ready = 1'b0;
    obs.delete();
    drive_table(1'b0);
    idle(5);
    check("ovf.no_overflow", 128'(stat_overflow), 128'(0));
    check("ovf.valid_held", 128'(avst_source_valid), 128'(1));
    idle(3);
    check("ovf.data_held", avst_source_data, vecs[0].data);
    check("ovf.sop_held", 128'(avst_source_startofpacket), 128'(1));
    drive_bins(16'h0020, 16, 1'b1);
    check("ovf.overflow", 128'(stat_overflow), 128'(1));
`ifdef PRACH_PACKET_STATS_EN
    check("ovf.drop_cnt", 128'(stat_drop_cnt), 128'(1));
    check("ovf.pkt_cnt", 128'(stat_pkt_cnt), 128'(2));
`else
    check("ovf.drop_cnt", 128'(stat_drop_cnt), 128'(0));
`endif
    drive_bins(16'h0030, 16, 1'b0);
    ready = 1'b1;
    idle(12);
    check("ovf.count", 128'(obs.size()), 128'(4));
    check_table("ovf", 0);

    // sync_in at bin 5 of channel 0
    do_reset();
    ready = 1'b1;
    obs.delete();
    drive_bins(16'h0000, 5, 1'b1);
    check("serr.before", 128'(stat_sync_err), 128'(0));
    drive_bins(16'h0040, 16, 1'b1);
    idle(10);
    check("serr.flag", 128'(stat_sync_err), 128'(1));
    check("serr.count", 128'(obs.size()), 128'(5));
    if (obs.size() >= 5) begin
      check("serr.first.data", obs[0].data, vecs[0].data);
      check("serr.restart.data", obs[1].data, 128'h0040FFC0_0041FFBF_0042FFBE_0043FFBD);
      check("serr.restart.sop", 128'(obs[1].sop), 128'(1));
      check("serr.restart.chn", 128'(obs[1].chn), 128'(0));
      check("serr.last.eop_chn", 128'({obs[4].eop, obs[4].chn}), 128'({1'b1, 16'd1}));
      $display("serr restart beat ch=%0d sop=%0b data=%h", obs[1].chn, obs[1].sop, obs[1].data);
    end

    // Reset with 3 beats queued and ready low
    do_reset();
    ready = 1'b0;
    drive_bins(16'h0000, 12, 1'b1);
    idle(4);
    check("rstmid.valid_before", 128'(avst_source_valid), 128'(1));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rstmid.valid_async", 128'(avst_source_valid), 128'(0));
    check("rstmid.data_async", avst_source_data, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    ready = 1'b1;
    obs.delete();
    drive_table(1'b0);
    idle(10);
    check("rstmid.count", 128'(obs.size()), 128'(4));
    check_table("rstmid", 0);

    // Valid bins with no sync produce nothing
    do_reset();
    ready = 1'b1;
    obs.delete();
    drive_bins(16'h0100, 100, 1'b0);
    idle(10);
    check("nosync.count", 128'(obs.size()), 128'(0));
    check("nosync.flags", 128'({stat_overflow, stat_sync_err}), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
